// File: rtl/msi_cache_ctrl.sv
// MSI coherence controller for a small direct-mapped line array: one outstanding
// processor request, a bus master port (GetS/GetX/PutM) and a snoop port.
`timescale 1ns/1ps
module msi_cache_ctrl #(
  parameter int IDX_W = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             done,
  output logic             bus_req,
  output logic [1:0]       bus_cmd,
  output logic [IDX_W-1:0] bus_idx,
  output logic [TAG_W-1:0] bus_tag,
  input  logic             bus_gnt,
  input  logic             bus_ack,
  input  logic             snp_valid,
  input  logic [1:0]       snp_cmd,
  input  logic [IDX_W-1:0] snp_idx,
  input  logic [TAG_W-1:0] snp_tag,
  output logic             snp_flush,
  output logic [1:0]       line_state
);
  localparam int LINES = 1 << IDX_W;
  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b10, ST_M = 2'b11;
  localparam logic [1:0] CMD_NONE = 2'b00, CMD_GETS = 2'b01, CMD_GETX = 2'b10, CMD_PUTM = 2'b11;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, ACQ, DONE} fsm_t;

  fsm_t             state_reg, state_next;
  logic             lat_we_reg;
  logic [IDX_W-1:0] lat_idx_reg;
  logic [TAG_W-1:0] lat_tag_reg;
  logic [1:0]       cmd_reg, cmd_next;
  logic             gnt_seen_reg, gnt_seen_next;
  logic             ack_fill, ack_evict;

  logic [1:0]       line_st  [LINES];
  logic [TAG_W-1:0] line_tag [LINES];

  logic             snp_hit, snp_changes, snp_on_lat;
  logic [1:0]       snp_st_new;
  logic [1:0]       cur_st;
  logic             tag_hit;

  // Snoop decode against the line the peer addresses.
  always_comb begin
    snp_hit    = snp_valid && (line_st[snp_idx] != ST_I) && (line_tag[snp_idx] == snp_tag);
    snp_st_new = line_st[snp_idx];
    snp_flush  = 1'b0;
    if (snp_hit) begin
      if (line_st[snp_idx] == ST_M && snp_cmd == CMD_GETS) begin
        snp_st_new = ST_S;
        snp_flush  = 1'b1;
      end else if (snp_cmd == CMD_GETX) begin
        snp_st_new = ST_I;
        snp_flush  = (line_st[snp_idx] == ST_M);
      end
    end
  end

  assign snp_changes = snp_hit && (snp_st_new != line_st[snp_idx]);
  assign snp_on_lat  = snp_changes && (snp_idx == lat_idx_reg);
  assign line_state  = line_st[req_idx];

  // Lookup sees the line as it will be after a same-cycle snoop.
  assign cur_st  = snp_on_lat ? snp_st_new : line_st[lat_idx_reg];
  assign tag_hit = (line_tag[lat_idx_reg] == lat_tag_reg) && (cur_st != ST_I);

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    gnt_seen_next = gnt_seen_reg;
    ack_fill      = 1'b0;
    ack_evict     = 1'b0;
    req_ready     = 1'b0;
    done          = 1'b0;
    bus_req       = 1'b0;
    bus_cmd       = CMD_NONE;
    bus_idx       = '0;
    bus_tag       = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        gnt_seen_next = 1'b0;
        cmd_next      = lat_we_reg ? CMD_GETX : CMD_GETS;
        if (tag_hit && (!lat_we_reg || cur_st == ST_M)) state_next = DONE;
        else if (!tag_hit && cur_st == ST_M)            state_next = WB;
        else                                            state_next = ACQ;
      end
      WB: begin
        if (!gnt_seen_reg) begin
          bus_req = 1'b1;
          bus_cmd = CMD_PUTM;
          bus_idx = lat_idx_reg;
          bus_tag = line_tag[lat_idx_reg];
          // A peer already took the Modified data: nothing left to write back.
          if (snp_on_lat)   state_next = ACQ;
          else if (bus_gnt) gnt_seen_next = 1'b1;
        end else if (bus_ack) begin
          ack_evict     = 1'b1;
          gnt_seen_next = 1'b0;
          state_next    = ACQ;
        end
      end
      ACQ: begin
        if (!gnt_seen_reg) begin
          bus_req = 1'b1;
          bus_cmd = cmd_reg;
          bus_idx = lat_idx_reg;
          bus_tag = lat_tag_reg;
          if (bus_gnt) gnt_seen_next = 1'b1;
        end else if (bus_ack) begin
          ack_fill      = 1'b1;
          gnt_seen_next = 1'b0;
          state_next    = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      lat_we_reg   <= 1'b0;
      lat_idx_reg  <= '0;
      lat_tag_reg  <= '0;
      cmd_reg      <= CMD_NONE;
      gnt_seen_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      gnt_seen_reg <= gnt_seen_next;
      if (state_reg == IDLE && req_valid) begin
        lat_we_reg  <= req_we;
        lat_idx_reg <= req_idx;
        lat_tag_reg <= req_tag;
      end
    end
  end

  // Per-line state/tag; a bus completion overrides a snoop on the same line.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    logic [1:0]       st_reg;
    logic [TAG_W-1:0] ltag_reg;
    logic             sel_ack, sel_snp;

    assign sel_ack      = (ack_fill || ack_evict) && (lat_idx_reg == IDX_W'(gi));
    assign sel_snp      = snp_changes && (snp_idx == IDX_W'(gi));
    assign line_st[gi]  = st_reg;
    assign line_tag[gi] = ltag_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_reg   <= ST_I;
        ltag_reg <= '0;
      end else if (sel_ack) begin
        if (ack_fill) begin
          st_reg   <= (cmd_reg == CMD_GETX) ? ST_M : ST_S;
          ltag_reg <= lat_tag_reg;
        end else begin
          st_reg <= ST_I;
        end
      end else if (sel_snp) begin
        st_reg <= snp_st_new;
      end
    end
  end
endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Directed bench for msi_cache_ctrl: array-level MSI model plus per-cycle compare.
`timescale 1ns/1ps
module tb_msi_cache_ctrl;
  localparam logic [1:0] I = 2'b00, S = 2'b10, M = 2'b11;
  localparam logic [1:0] GETS = 2'b01, GETX = 2'b10, PUTM = 2'b11;

  logic       clk, reset;
  logic       req_valid, req_we;
  logic [1:0] req_idx;
  logic [3:0] req_tag;
  logic       req_ready, done, bus_req;
  logic [1:0] bus_cmd;
  logic [1:0] bus_idx;
  logic [3:0] bus_tag;
  logic       bus_gnt, bus_ack;
  logic       snp_valid;
  logic [1:0] snp_cmd;
  logic [1:0] snp_idx;
  logic [3:0] snp_tag;
  logic       snp_flush;
  logic [1:0] line_state;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  // Model: expected MSI state and tag per line.
  logic [1:0] m_st  [4];
  logic [3:0] m_tag [4];
  logic       ack_upd;
  logic [1:0] ack_idx, ack_st;
  logic [3:0] ack_tag;

  msi_cache_ctrl #(.IDX_W(2), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_idx(req_idx), .req_tag(req_tag),
    .req_ready(req_ready), .done(done),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_idx(bus_idx), .bus_tag(bus_tag),
    .bus_gnt(bus_gnt), .bus_ack(bus_ack),
    .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_idx(snp_idx), .snp_tag(snp_tag),
    .snp_flush(snp_flush), .line_state(line_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_st[i]  <= I;
        m_tag[i] <= 4'd0;
      end
    end else begin
      if (snp_valid && m_st[snp_idx] != I && m_tag[snp_idx] == snp_tag) begin
        if (snp_cmd == GETX) m_st[snp_idx] <= I;
        else if (snp_cmd == GETS && m_st[snp_idx] == M) m_st[snp_idx] <= S;
      end
      if (ack_upd) begin
        m_st[ack_idx]  <= ack_st;
        m_tag[ack_idx] <= ack_tag;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("line_state_model", int'(line_state), int'(m_st[req_idx]));
      check("snp_flush_model", int'(snp_flush),
            int'(snp_valid && m_st[snp_idx] == M && m_tag[snp_idx] == snp_tag &&
                 (snp_cmd == GETS || snp_cmd == GETX)));
      if (!bus_req) check("bus_cmd_idle", int'(bus_cmd), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_snp(input logic [1:0] c, input logic [1:0] i, input logic [3:0] t);
    snp_valid = 1'b1; snp_cmd = c; snp_idx = i; snp_tag = t;
  endtask

  task automatic issue(input logic we, input logic [1:0] idx, input logic [3:0] tag);
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready_wait", int'(req_ready), 1);
    req_valid = 1'b1; req_we = we; req_idx = idx; req_tag = tag;
    tick();
    req_valid = 1'b0;
    check("accepted", int'(req_ready), 0);
  endtask

  // snp_when: 0 none, 1 snoop before grant, 2 snoop with ack, 3 snoop before grant and abandon
  task automatic bus_phase(input logic [1:0] cmd, input logic [1:0] idx, input logic [3:0] tag,
                           input logic [1:0] new_st, input logic [3:0] new_tag, input int snp_when,
                           input logic [1:0] sc, input logic [1:0] si, input logic [3:0] st);
    int n = 0;
    while (!bus_req && n < 20) begin tick(); n++; end
    check("bus_req_wait", int'(bus_req), 1);
    check("bus_cmd", int'(bus_cmd), int'(cmd));
    check("bus_idx", int'(bus_idx), int'(idx));
    check("bus_tag", int'(bus_tag), int'(tag));
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    check("ack_before_gnt_ignored", int'(bus_req), 1);
    if (snp_when == 1 || snp_when == 3) begin
      drive_snp(sc, si, st);
      tick();
      snp_valid = 1'b0;
    end
    if (snp_when == 3) return;
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check("bus_req_drop_after_gnt", int'(bus_req), 0);
    tick();
    bus_ack = 1'b1; ack_upd = 1'b1; ack_idx = idx; ack_st = new_st; ack_tag = new_tag;
    if (snp_when == 2) drive_snp(sc, si, st);
    tick();
    bus_ack = 1'b0; ack_upd = 1'b0; snp_valid = 1'b0;
  endtask

  task automatic finish_req();
    check("done", int'(done), 1);
    check("done_no_bus", int'(bus_req), 0);
    tick();
    check("done_one_cycle", int'(done), 0);
    check("back_to_idle", int'(req_ready), 1);
  endtask

  task automatic snoop(input logic [1:0] c, input logic [1:0] i, input logic [3:0] t, input int fl);
    drive_snp(c, i, t);
    @(negedge clk);
    check("snp_flush_lit", int'(snp_flush), fl);
    @(posedge clk);
    #1;
    snp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_idx = '0; req_tag = '0;
    bus_gnt = 1'b0; bus_ack = 1'b0;
    snp_valid = 1'b0; snp_cmd = '0; snp_idx = '0; snp_tag = '0;
    ack_upd = 1'b0; ack_idx = '0; ack_st = '0; ack_tag = '0;
    #2 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_bus_req", int'(bus_req), 0);
    check("rst_bus_cmd", int'(bus_cmd), 0);
    check("rst_bus_addr", int'({bus_idx, bus_tag}), 0);
    check("rst_snp_flush", int'(snp_flush), 0);
    for (int i = 0; i < 4; i++) begin
      req_idx = 2'(i);
      #1 check("rst_line_state", int'(line_state), 0);
    end
    tick();
    reset = 1'b1;
    tick();

    // Read miss on I
    issue(1'b0, 2'd1, 4'd5);
    bus_phase(GETS, 2'd1, 4'd5, S, 4'd5, 0, '0, '0, '0);
    check("read_miss_state", int'(line_state), 2);
    finish_req();
    $display("txn read-miss idx1 tag5 -> S");

    // Upgrade, then write hit in two cycles
    issue(1'b1, 2'd1, 4'd5);
    bus_phase(GETX, 2'd1, 4'd5, M, 4'd5, 0, '0, '0, '0);
    check("upgrade_state", int'(line_state), 3);
    finish_req();
    issue(1'b1, 2'd1, 4'd5);
    check("hit_lookup_no_bus", int'(bus_req), 0);
    tick();
    finish_req();
    $display("txn write-upgrade idx1 tag5 -> M, then write hit");

    // Conflict miss on M: writeback then GetX
    issue(1'b1, 2'd1, 4'd6);
    bus_phase(PUTM, 2'd1, 4'd5, I, 4'd5, 0, '0, '0, '0);
    bus_phase(GETX, 2'd1, 4'd6, M, 4'd6, 0, '0, '0, '0);
    check("evict_refill_state", int'(line_state), 3);
    finish_req();
    $display("txn write idx1 tag6 over M tag5 -> PutM, GetX");

    // Snoops on line 1 (M tag6)
    snoop(GETS, 2'd1, 4'd6, 1);
    check("snp_gets_state", int'(line_state), 2);
    snoop(GETX, 2'd1, 4'd9, 0);
    check("snp_tag_miss_state", int'(line_state), 2);
    snoop(GETX, 2'd1, 4'd6, 0);
    check("snp_getx_state", int'(line_state), 0);
    $display("txn snoops idx1: GetS M->S, GetX other tag, GetX S->I");

    // Snoop invalidates during upgrade
    issue(1'b0, 2'd2, 4'd3);
    bus_phase(GETS, 2'd2, 4'd3, S, 4'd3, 0, '0, '0, '0);
    finish_req();
    issue(1'b1, 2'd2, 4'd3);
    bus_phase(GETX, 2'd2, 4'd3, M, 4'd3, 1, GETX, 2'd2, 4'd3);
    check("upgrade_after_snp_inval", int'(line_state), 3);
    finish_req();
    $display("txn upgrade idx2 tag3 with snoop GetX in ACQ -> M");

    // Snoop and ack on the same line in the same cycle
    issue(1'b0, 2'd0, 4'd1);
    bus_phase(GETS, 2'd0, 4'd1, S, 4'd1, 0, '0, '0, '0);
    finish_req();
    issue(1'b1, 2'd0, 4'd1);
    bus_phase(GETX, 2'd0, 4'd1, M, 4'd1, 2, GETX, 2'd0, 4'd1);
    check("ack_beats_snoop", int'(line_state), 3);
    finish_req();
    $display("txn upgrade idx0 tag1 with simultaneous snoop -> M");

    // Writeback abandoned by snoop before grant
    issue(1'b1, 2'd2, 4'd4);
    bus_phase(PUTM, 2'd2, 4'd3, I, 4'd3, 3, GETS, 2'd2, 4'd3);
    bus_phase(GETX, 2'd2, 4'd4, M, 4'd4, 0, '0, '0, '0);
    check("abandon_wb_state", int'(line_state), 3);
    finish_req();
    $display("txn write idx2 tag4, PutM abandoned by snoop -> M");

    // Reset during WB after grant
    issue(1'b1, 2'd2, 4'd7);
    begin
      int n = 0;
      while (!bus_req && n < 20) begin tick(); n++; end
    end
    check("wb_cmd", int'(bus_cmd), int'(PUTM));
    check("wb_tag", int'(bus_tag), 4);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_bus_req", int'(bus_req), 0);
    check("midrst_bus_cmd", int'(bus_cmd), 0);
    check("midrst_req_ready", int'(req_ready), 1);
    check("midrst_done", int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      req_idx = 2'(i);
      #1 check("midrst_line_state", int'(line_state), 0);
    end
    tick();
    reset = 1'b1;
    tick();
    issue(1'b0, 2'd1, 4'd5);
    bus_phase(GETS, 2'd1, 4'd5, S, 4'd5, 0, '0, '0, '0);
    check("post_rst_read", int'(line_state), 2);
    finish_req();
    $display("txn reset in WB, then read idx1 tag5 -> S");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
